// File: rtl/hex_display_bank.sv
// Multi-digit hex seven-segment driver: captures a value, scans leading zeros, commits atomically.
// Latency DIGITS+2 from accept to seg_out; s_ready is low while scanning (one value per DIGITS+1 cycles).
// Optional per-digit blinking when HEX_DISPLAY_BLINK_EN is defined.
module hex_display_bank #(
  parameter int DIGITS    = 8,
  parameter bit INVERT    = 1'b1,
  parameter bit LZ_BLANK  = 1'b1,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] s_value,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                enable,
  input  logic [DIGITS-1:0]   blink_mask,
  output logic [7*DIGITS-1:0] seg_out
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

  if (DIGITS < 1 || BLINK_DIV < 1) begin : g_param_check
    $error("hex_display_bank: DIGITS and BLINK_DIV must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state, state_nxt;

  logic [4*DIGITS-1:0] shadow, disp_val;
  logic [DIGITS-1:0]   lz_mask, disp_blank;
  logic [IDX_W-1:0]    scan_idx;
  logic                seen_nz, shown, blink_phase, accept;
  logic [3:0]          cur_nib;
  logic [7*DIGITS-1:0] seg_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // COMMIT also accepts, so back-to-back values overlap the commit with the next capture.
  assign s_ready = (state == IDLE) || (state == COMMIT);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (scan_idx == '0) state_nxt = COMMIT;
      COMMIT:  state_nxt = accept ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur_nib = 4'h0;
    for (int i = 0; i < DIGITS; i++)
      if (scan_idx == IDX_W'(i)) cur_nib = shadow[4*i +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      scan_idx   <= '0;
      seen_nz    <= 1'b0;
      lz_mask    <= '0;
      disp_val   <= '0;
      disp_blank <= '0;
      shown      <= 1'b0;
    end else begin
      if (accept) begin
        shadow   <= s_value;
        scan_idx <= IDX_TOP;
        seen_nz  <= 1'b0;
      end
      if (state == SCAN) begin
        for (int i = 0; i < DIGITS; i++)
          if (scan_idx == IDX_W'(i))
            lz_mask[i] <= LZ_BLANK && !seen_nz && (cur_nib == 4'h0) && (i != 0);
        if (cur_nib != 4'h0) seen_nz <= 1'b1;
        if (scan_idx != '0) scan_idx <= scan_idx - 1'b1;
      end
      if (state == COMMIT) begin
        disp_val   <= shadow;
        disp_blank <= lz_mask;
        shown      <= 1'b1;
      end
    end
  end

`ifdef HEX_DISPLAY_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
  logic [CNT_W-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  assign blink_phase = 1'b1;
`endif

  always_comb begin
    seg_nxt = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!enable || !shown || disp_blank[i] || (blink_mask[i] && !blink_phase))
        seg_nxt[7*i +: 7] = 7'h00;
      else
        seg_nxt[7*i +: 7] = hex7(disp_val[4*i +: 4]);
    end
    if (INVERT) seg_nxt = ~seg_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_out <= {(7*DIGITS){INVERT}};
    else        seg_out <= seg_nxt;
  end
endmodule

// File: tb/tb_hex_display_bank.sv
// Bench for hex_display_bank: two instances (active-high with blanking, active-low without)
// against a cycle-level model of accept/commit timing and display rules.
module tb_hex_display_bank;
  localparam int D  = 4;
  localparam int BD = 4;
`ifdef HEX_DISPLAY_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [4*D-1:0] s_value = '0;
  logic           s_valid = 1'b0;
  logic           enable = 1'b1;
  logic [D-1:0]   blink_mask = '0;
  logic           s_ready_a, s_ready_b;
  logic [7*D-1:0] seg_a, seg_b;
  int             checks = 0;
  int             failures = 0;
  bit             chk_on = 1'b0;

  always #5 clk = ~clk;

  hex_display_bank #(.DIGITS(D), .INVERT(1'b0), .LZ_BLANK(1'b1), .BLINK_DIV(BD)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .s_value(s_value), .s_valid(s_valid), .s_ready(s_ready_a),
    .enable(enable), .blink_mask(blink_mask), .seg_out(seg_a));

  hex_display_bank #(.DIGITS(D), .INVERT(1'b1), .LZ_BLANK(1'b0), .BLINK_DIV(BD)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .s_value(s_value), .s_valid(s_valid), .s_ready(s_ready_b),
    .enable(enable), .blink_mask(blink_mask), .seg_out(seg_b));

  logic [6:0] enc_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [7*D-1:0] seg4(input logic [6:0] d3, input logic [6:0] d2,
                                          input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  // Display rule: digit i is dark if disabled, nothing committed yet, blinking off-phase,
  // or (with blanking) every nibble from i upward is zero and i is not the lowest digit.
  function automatic logic [7*D-1:0] expect_seg(input logic [15:0] val, input bit shown,
      input bit en, input logic [D-1:0] mask, input bit phase, input bit lz, input bit inv);
    logic [7*D-1:0] r;
    bit blank;
    r = '0;
    for (int i = 0; i < D; i++) begin
      blank = !en || !shown || (mask[i] && !phase);
      if (lz && i > 0 && (val >> (4*i)) == 16'h0) blank = 1'b1;
      if (!blank) r[7*i +: 7] = enc_tab[val[4*i +: 4]];
    end
    return inv ? ~r : r;
  endfunction

  task automatic check(input string name, input logic [7*D-1:0] act, input logic [7*D-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edges counted since reset; an accepted value commits DIGITS+1 edges later.
  int             m_e, ready_edge, pend_edge;
  bit             pend_vld, m_shown, ph;
  logic [15:0]    pend_val, m_val;
  logic [7*D-1:0] exp_a, exp_b;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_e = 0; ready_edge = 0; pend_vld = 1'b0; pend_edge = 0;
      m_val = '0; m_shown = 1'b0; pend_val = '0;
      exp_a = '0; exp_b = '1;
    end else begin
      ph = 1'b1;
      if (BLINK_ON && ((m_e / BD) % 2 == 1)) ph = 1'b0;
      exp_a = expect_seg(m_val, m_shown, enable, blink_mask, ph, 1'b1, 1'b0);
      exp_b = expect_seg(m_val, m_shown, enable, blink_mask, ph, 1'b0, 1'b1);
      m_e++;
      if (pend_vld && m_e == pend_edge) begin
        m_val = pend_val; m_shown = 1'b1; pend_vld = 1'b0;
      end
      if (s_valid && m_e >= ready_edge) begin
        pend_val = s_value; pend_vld = 1'b1;
        pend_edge = m_e + D + 1; ready_edge = m_e + D + 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("seg_a", seg_a, exp_a);
      check("seg_b", seg_b, exp_b);
      check("ready_a", 28'(s_ready_a), 28'(m_e + 1 >= ready_edge));
      check("ready_b", 28'(s_ready_b), 28'(m_e + 1 >= ready_edge));
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [15:0] v);
    bit done;
    done = 1'b0;
    s_value = v;
    s_valid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      if (s_ready_a) begin
        @(posedge clk);
        @(negedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout: actual=no_accept required=accept value=%h", v);
    end
    s_valid = 1'b0;
    s_value = 16'($urandom);
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] r;
    r = 16'($urandom);
    for (int i = 0; i < D; i++)
      if ($urandom_range(0, 1) == 0) r[4*i +: 4] = 4'h0;
    return r;
  endfunction

  initial begin
    int cnt7f, changes;
    logic [6:0] prev, cur;
    repeat (3) @(negedge clk);
    check("rst_seg_a", seg_a, '0);
    check("rst_seg_b", seg_b, '1);
    check("rst_ready", 28'(s_ready_a), 28'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;
    check("post_rst_seg_a", seg_a, '0);

    // Leading-zero blanking and handshake timing
    send(16'h00A5);
    for (int j = 0; j < 4; j++) begin
      check("busy_ready", 28'(s_ready_a), 28'd0);
      @(negedge clk);
    end
    check("commit_ready", 28'(s_ready_a), 28'd1);
    @(negedge clk);
    check("pre_show_a", seg_a, '0);
    @(negedge clk);
    check("lz_00A5_a", seg_a, seg4(7'h00, 7'h00, 7'h77, 7'h6D));
    check("nolz_00A5_b", seg_b, ~seg4(7'h3F, 7'h3F, 7'h77, 7'h6D));

    send(16'h0000);
    repeat (6) @(negedge clk);
    check("zero_a", seg_a, seg4(7'h00, 7'h00, 7'h00, 7'h3F));
    check("zero_b", seg_b, ~seg4(7'h3F, 7'h3F, 7'h3F, 7'h3F));

    send(16'h1000);
    repeat (6) @(negedge clk);
    check("emb_zero_a", seg_a, seg4(7'h06, 7'h3F, 7'h3F, 7'h3F));

    // Backpressure: held valid, value changes while busy
    s_value = 16'h1234; s_valid = 1'b1;
    @(negedge clk);
    check("bp_busy", 28'(s_ready_a), 28'd0);
    @(negedge clk);
    s_value = 16'h5678;
    repeat (4) @(negedge clk);
    check("bp_second_accept", 28'(s_ready_a), 28'd0);
    s_valid = 1'b0;
    @(negedge clk);
    check("bp_1234", seg_a, seg4(7'h06, 7'h5B, 7'h4F, 7'h66));
    repeat (4) @(negedge clk);
    check("bp_hold_1234", seg_a, seg4(7'h06, 7'h5B, 7'h4F, 7'h66));
    @(negedge clk);
    check("bp_5678", seg_a, seg4(7'h6D, 7'h7D, 7'h07, 7'h7F));

    // Reset during scan discards the captured value
    send(16'hFFFF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midscan_rst_seg", seg_a, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midscan_never_a", seg_a, '0);
    check("midscan_never_b", seg_b, '1);
    check("midscan_ready", 28'(s_ready_a), 28'd1);

    // Asynchronous reset pulse mid-cycle
    send(16'h0C0E);
    repeat (6) @(negedge clk);
    check("show_0C0E", seg_a, seg4(7'h00, 7'h39, 7'h3F, 7'h79));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a", seg_a, '0);
    check("async_rst_b", seg_b, '1);
    check("async_rst_ready", 28'(s_ready_a), 28'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Enable gating
    send(16'h0008);
    repeat (6) @(negedge clk);
    check("show_0008", seg_a, seg4(7'h00, 7'h00, 7'h00, 7'h7F));
    enable = 1'b0;
    @(negedge clk);
    check("disable_a", seg_a, '0);
    check("disable_b", seg_b, '1);
    enable = 1'b1;
    @(negedge clk);
    check("reenable_a", seg_a, seg4(7'h00, 7'h00, 7'h00, 7'h7F));

`ifdef HEX_DISPLAY_BLINK_EN
    blink_mask = 4'b0001;
    @(negedge clk);
    cnt7f = 0; changes = 0; prev = seg_a[6:0];
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      cur = seg_a[6:0];
      if (cur == 7'h7F) cnt7f++;
      if (cur != prev) changes++;
      prev = cur;
    end
    check("blink_on_count", 28'(cnt7f), 28'd8);
    checks++;
    if (changes != 3 && changes != 4) begin
      failures++;
      $display("FAIL blink_changes: actual=%0d required=3_or_4", changes);
    end
    blink_mask = '0;
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!s_valid || $urandom_range(0, 3) == 0) s_value = rand_val();
      s_valid    = ($urandom_range(0, 2) != 0);
      enable     = ($urandom_range(0, 7) != 0);
      blink_mask = 4'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
